// File: rtl/spi_byte_sequencer.sv
// Byte sequencer between a streaming byte interface and a single-byte SPI driver.
// TX bytes are queued, handed to the driver one at a time, and received bytes are queued for readout.

module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       empty,
  output logic       full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign head    = mem[rd_ptr];
  assign pop_ok  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO may still take a push.
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

module spi_byte_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic [7:0] drv_data_in,
  output logic       drv_start,
  input  logic       drv_en,
  input  logic [7:0] drv_data_out,
  output logic       busy,
  output logic       rx_overflow,
  output logic       timeout_err
);

  localparam int GAP_LEN = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
  localparam logic [7:0] GAP_LAST = 8'(GAP_LEN - 1);
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_EN,
    WAIT_DONE,
    CAPTURE,
    GAP
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] timer;
  logic [7:0] gap_cnt;

  logic       tx_push;
  logic       tx_pop;
  logic [7:0] tx_head;
  logic       tx_empty;
  logic       tx_full;

  logic       rx_push;
  logic       rx_pop;
  logic [7:0] rx_head;
  logic       rx_empty;
  logic       rx_full;

  logic       timeout_hit;
  logic       overflow_hit;
  logic       start_next;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_push),
    .push_data (tx_data),
    .pop       (tx_pop),
    .head      (tx_head),
    .empty     (tx_empty),
    .full      (tx_full)
  );

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push),
    .push_data (drv_data_out),
    .pop       (rx_pop),
    .head      (rx_head),
    .empty     (rx_empty),
    .full      (rx_full)
  );

  assign tx_ready = !tx_full;
  assign tx_push  = tx_valid && tx_ready;
  assign tx_pop   = (state == LOAD) && !tx_empty;

  assign rx_valid = !rx_empty;
  assign rx_data  = rx_valid ? rx_head : 8'h00;
  assign rx_pop   = rx_valid && rx_ready;

  assign busy = (state != IDLE) || !tx_empty;

  // The timer holds cycles already spent in the wait state minus one, so the
  // abort lands on the TIMEOUT-th cycle.
  assign timeout_hit = (timer == TO_LAST) &&
                       (((state == WAIT_EN) && !drv_en) ||
                        ((state == WAIT_DONE) && drv_en));

  assign overflow_hit = (state == CAPTURE) && rx_full && !rx_pop;

  always_comb begin
    rx_push    = 1'b0;
    state_next = state;
    case (state)
      IDLE: begin
        if (!tx_empty) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        state_next = tx_empty ? IDLE : WAIT_EN;
      end
      WAIT_EN: begin
        if (drv_en) begin
          state_next = WAIT_DONE;
        end else if (timeout_hit) begin
          state_next = GAP;
        end
      end
      WAIT_DONE: begin
        if (!drv_en) begin
          state_next = CAPTURE;
        end else if (timeout_hit) begin
          state_next = GAP;
        end
      end
      CAPTURE: begin
        rx_push    = 1'b1;
        state_next = GAP;
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_next = tx_empty ? IDLE : LOAD;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // drv_start is a flop decoded from the next state, so it cannot glitch.
  assign start_next = (state_next == WAIT_EN) || (state_next == WAIT_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      drv_start   <= 1'b0;
      drv_data_in <= 8'h00;
      timer       <= 8'h00;
      gap_cnt     <= 8'h00;
      rx_overflow <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state     <= state_next;
      drv_start <= start_next;
      if (tx_pop) begin
        drv_data_in <= tx_head;
      end
      if ((state_next != state) && start_next) begin
        timer <= 8'h00;
      end else if (timer != 8'hFF) begin
        timer <= timer + 8'd1;
      end
      if ((state_next == GAP) && (state != GAP)) begin
        gap_cnt <= 8'h00;
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt + 8'd1;
      end
      if (overflow_hit) begin
        rx_overflow <= 1'b1;
      end
      if (timeout_hit) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_byte_sequencer.sv
// Directed bench for spi_byte_sequencer with a behavioural SPI driver model.
// Expected values come from the vector table and hand-derived cycle counts.

module tb_spi_byte_sequencer;

  localparam int GAP_CYCLES = 2;
  localparam int TIMEOUT    = 255;
  localparam int EN_DELAY   = 2;
  localparam int EN_LEN     = 20;

  logic       clk;
  logic       rst;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic [7:0] drv_data_in;
  logic       drv_start;
  logic       drv_en;
  logic [7:0] drv_data_out;
  logic       busy;
  logic       rx_overflow;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;

  logic       model_on;
  logic [7:0] resp_q [$];
  logic [7:0] sent_q [$];
  int         drv_phase;
  int         drv_cnt;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] resp;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs [5];

  spi_byte_sequencer #(
    .FIFO_DEPTH (4),
    .GAP_CYCLES (GAP_CYCLES),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .drv_data_in  (drv_data_in),
    .drv_start    (drv_start),
    .drv_en       (drv_en),
    .drv_data_out (drv_data_out),
    .busy         (busy),
    .rx_overflow  (rx_overflow),
    .timeout_err  (timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver model: raises drv_en EN_DELAY cycles after seeing drv_start, holds it
  // EN_LEN cycles, then drops it with the next queued response byte.
  initial begin
    drv_en       = 1'b0;
    drv_data_out = 8'h00;
    drv_phase    = 0;
    drv_cnt      = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        drv_en    = 1'b0;
        drv_phase = 0;
      end else begin
        case (drv_phase)
          0: begin
            if (model_on && drv_start) begin
              sent_q.push_back(drv_data_in);
              drv_cnt   = 0;
              drv_phase = 1;
            end
          end
          1: begin
            if (!drv_start) begin
              drv_phase = 0;
            end else begin
              drv_cnt++;
              if (drv_cnt == EN_DELAY) begin
                drv_en    = 1'b1;
                drv_cnt   = 0;
                drv_phase = 2;
              end
            end
          end
          2: begin
            if (!drv_start) begin
              drv_en    = 1'b0;
              drv_phase = 0;
            end else begin
              drv_cnt++;
              if (drv_cnt == EN_LEN) begin
                if (resp_q.size() > 0) begin
                  drv_data_out = resp_q.pop_front();
                end else begin
                  drv_data_out = 8'hEE;
                end
                drv_en    = 1'b0;
                drv_phase = 3;
              end
            end
          end
          default: begin
            if (!drv_start) begin
              drv_phase = 0;
            end
          end
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    int n;
    n = 0;
    while (!tx_ready && n < 300) begin
      tick();
      n++;
    end
    if (!tx_ready) begin
      checkOutput("push_wait_tx_ready", {31'd0, tx_ready}, 32'd1);
    end else begin
      tx_valid = 1'b1;
      tx_data  = b;
      tick();
      tx_valid = 1'b0;
    end
  endtask

  task automatic wait_start(input logic lvl, input int budget, input string name);
    int n;
    n = 0;
    while (drv_start !== lvl && n < budget) begin
      tick();
      n++;
    end
    checkOutput(name, {31'd0, drv_start}, {31'd0, lvl});
  endtask

  task automatic wait_rx(input int budget, input string name);
    int n;
    n = 0;
    while (!rx_valid && n < budget) begin
      tick();
      n++;
    end
    checkOutput(name, {31'd0, rx_valid}, 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    checkOutput(name, {31'd0, busy}, 32'd0);
  endtask

  task automatic pop_rx();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_drv_start"}, {31'd0, drv_start}, 32'd0);
    checkOutput({tag, "_drv_data_in"}, {24'd0, drv_data_in}, 32'h00);
    checkOutput({tag, "_tx_ready"}, {31'd0, tx_ready}, 32'd1);
    checkOutput({tag, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
    checkOutput({tag, "_rx_data"}, {24'd0, rx_data}, 32'h00);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_rx_overflow"}, {31'd0, rx_overflow}, 32'd0);
    checkOutput({tag, "_timeout_err"}, {31'd0, timeout_err}, 32'd0);
  endtask

  initial begin
    int n;
    int ready_early;
    bit seen_low;
    logic [7:0] exp_ovf [4];

    vecs[0] = '{tx: 8'h01, resp: 8'h81, exp_rx: 8'h81};
    vecs[1] = '{tx: 8'h02, resp: 8'h82, exp_rx: 8'h82};
    vecs[2] = '{tx: 8'h03, resp: 8'h83, exp_rx: 8'h83};
    vecs[3] = '{tx: 8'h04, resp: 8'h84, exp_rx: 8'h84};
    vecs[4] = '{tx: 8'h05, resp: 8'h85, exp_rx: 8'h85};
    exp_ovf[0] = 8'h21;
    exp_ovf[1] = 8'h22;
    exp_ovf[2] = 8'h23;
    exp_ovf[3] = 8'h25;

    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    rx_ready = 1'b0;
    model_on = 1'b1;
    tick();
    tick();
    check_reset_values("reset");
    rst = 1'b0;
    tick();

    $display("[TB] single byte transfer");
    resp_q.push_back(8'h3C);
    sent_q.delete();
    applyStimulus(8'hA5);
    checkOutput("single_busy_after_push", {31'd0, busy}, 32'd1);
    wait_start(1'b1, 10, "single_start_rise");
    checkOutput("single_drv_data_in", {24'd0, drv_data_in}, 32'hA5);
    wait_start(1'b0, 60, "single_start_fall");
    checkOutput("single_rx_valid_in_capture", {31'd0, rx_valid}, 32'd0);
    tick();
    checkOutput("single_rx_valid_after", {31'd0, rx_valid}, 32'd1);
    checkOutput("single_rx_data", {24'd0, rx_data}, 32'h3C);
    n = 1;
    while (busy && n < 20) begin
      checkOutput("single_gap_start_low", {31'd0, drv_start}, 32'd0);
      n++;
      tick();
    end
    checkOutput("single_gap_len", n, GAP_CYCLES + 1);
    checkOutput("single_sent_byte", {24'd0, sent_q[0]}, 32'hA5);
    pop_rx();
    checkOutput("single_rx_empty", {31'd0, rx_valid}, 32'd0);

    $display("[TB] back-to-back table");
    sent_q.delete();
    for (int i = 0; i < 5; i++) resp_q.push_back(vecs[i].resp);
    applyStimulus(vecs[0].tx);
    wait_start(1'b1, 10, "b2b_first_start");
    for (int i = 1; i < 5; i++) applyStimulus(vecs[i].tx);
    checkOutput("b2b_tx_full", {31'd0, tx_ready}, 32'd0);
    // Keep offering a byte while full; it must not be taken before the next LOAD pop lands.
    tx_valid    = 1'b1;
    tx_data     = 8'h99;
    ready_early = 0;
    seen_low    = 1'b0;
    n           = 0;
    while (n < 200) begin
      tick();
      n++;
      if (drv_start && seen_low) break;
      if (!drv_start) seen_low = 1'b1;
      if (tx_ready) ready_early++;
    end
    tx_valid = 1'b0;
    checkOutput("b2b_second_start", {31'd0, drv_start}, 32'd1);
    checkOutput("b2b_ready_held_low", ready_early, 0);
    checkOutput("b2b_ready_after_pop", {31'd0, tx_ready}, 32'd1);
    checkOutput("b2b_second_data", {24'd0, drv_data_in}, {24'd0, vecs[1].tx});
    for (int i = 0; i < 5; i++) begin
      wait_rx(200, "b2b_rx_wait");
      checkOutput($sformatf("b2b_rx_%0d", i), {24'd0, rx_data}, {24'd0, vecs[i].exp_rx});
      pop_rx();
    end
    wait_idle(100, "b2b_idle");
    checkOutput("b2b_sent_count", sent_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < sent_q.size())
        checkOutput($sformatf("b2b_sent_%0d", i), {24'd0, sent_q[i]}, {24'd0, vecs[i].tx});
    end
    checkOutput("b2b_no_overflow", {31'd0, rx_overflow}, 32'd0);

    $display("[TB] rx full and overflow");
    for (int i = 0; i < 6; i++) resp_q.push_back(8'h20 + 8'(i));
    for (int i = 0; i < 5; i++) applyStimulus(8'h10 + 8'(i));
    wait_idle(400, "ovf_idle");
    checkOutput("ovf_flag", {31'd0, rx_overflow}, 32'd1);
    checkOutput("ovf_head", {24'd0, rx_data}, 32'h20);
    applyStimulus(8'h15);
    wait_start(1'b1, 10, "ovf6_start");
    wait_start(1'b0, 60, "ovf6_capture");
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    wait_idle(20, "ovf6_idle");
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("ovf_rx_%0d", i), {24'd0, rx_data}, {24'd0, exp_ovf[i]});
      pop_rx();
    end
    checkOutput("ovf_rx_drained", {31'd0, rx_valid}, 32'd0);

    $display("[TB] timeout");
    model_on = 1'b0;
    resp_q.delete();
    resp_q.push_back(8'h42);
    applyStimulus(8'h66);
    applyStimulus(8'h77);
    wait_start(1'b1, 10, "to_start");
    checkOutput("to_first_data", {24'd0, drv_data_in}, 32'h66);
    n = 0;
    while (drv_start && n < 400) begin
      n++;
      tick();
    end
    checkOutput("to_wait_cycles", n, TIMEOUT);
    checkOutput("to_err_flag", {31'd0, timeout_err}, 32'd1);
    checkOutput("to_start_low", {31'd0, drv_start}, 32'd0);
    checkOutput("to_no_rx_push", {31'd0, rx_valid}, 32'd0);
    model_on = 1'b1;
    n = 0;
    while (!drv_start && n < 20) begin
      n++;
      tick();
    end
    checkOutput("to_gap_low_cycles", n, GAP_CYCLES + 1);
    checkOutput("to_next_data", {24'd0, drv_data_in}, 32'h77);
    wait_rx(60, "to_next_rx_wait");
    checkOutput("to_next_rx", {24'd0, rx_data}, 32'h42);
    pop_rx();
    wait_idle(20, "to_idle");

    $display("[TB] reset during transfer");
    resp_q.delete();
    resp_q.push_back(8'h11);
    applyStimulus(8'h5A);
    applyStimulus(8'h99);
    n = 0;
    while (!drv_en && n < 20) begin
      n++;
      tick();
    end
    checkOutput("mid_drv_en_seen", {31'd0, drv_en}, 32'd1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_reset_values("mid_reset");
    rst = 1'b0;
    resp_q.delete();
    resp_q.push_back(8'hAB);
    sent_q.delete();
    tick();
    checkOutput("mid_still_idle", {31'd0, busy}, 32'd0);
    applyStimulus(8'h55);
    wait_start(1'b1, 10, "post_start");
    checkOutput("post_drv_data", {24'd0, drv_data_in}, 32'h55);
    wait_rx(60, "post_rx_wait");
    checkOutput("post_rx_data", {24'd0, rx_data}, 32'hAB);
    pop_rx();
    wait_idle(20, "post_idle");
    checkOutput("post_sent_count", sent_q.size(), 1);
    checkOutput("post_no_timeout", {31'd0, timeout_err}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
